// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and helpers for clkdiv_arbiter.
package clkdiv_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        RUN   = 5'b00100,
        DRAIN = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    function automatic int onehot2idx(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at pointer; pointer lives in the parent.
module rr_arbiter
    import clkdiv_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] pointer,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++)
            if (!found && req[(int'(pointer) + k) % NREQ]) begin
                gnt[(int'(pointer) + k) % NREQ] = 1'b1;
                found = 1'b1;
            end
    end

    assign idx = IDX_W'(onehot2idx(32'(gnt)));

endmodule

// File: rtl/clkdiv_arbiter.sv
// clkdiv_arbiter: round-robin owner of a shared clkdiv, runs bursts of N output periods.
// Define CLKDIV_ARBITER_ABORT_EN to let the owner cut a burst short by dropping its request.
module clkdiv_arbiter
    import clkdiv_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int LEN_W     = 8,
    parameter int IDLE_HIGH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*LEN_W-1:0] len_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic                  busy_o,
    output logic [LEN_W-1:0]      cnt_o,
    output logic                  div_enable_o,
    input  logic                  div_idle_i,
    input  logic                  div_clk_i
);

    localparam int   IDX_W = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam logic IH    = 1'(IDLE_HIGH);

    state_t           state, next;
    logic [IDX_W-1:0] ptr, owner, win_idx;
    logic [NREQ-1:0]  win_gnt, own_oh;
    logic [LEN_W-1:0] len, cnt, cnt_inc, win_len;
    logic             past_clk, ret_edge, abort;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req     (req_i),
        .pointer (ptr),
        .gnt     (win_gnt),
        .idx     (win_idx)
    );

    assign win_len  = len_i[int'(win_idx)*LEN_W +: LEN_W];
    assign own_oh   = NREQ'(1) << owner;
    assign cnt_inc  = cnt + 1'b1;
    assign ret_edge = (div_clk_i == IH) && (past_clk != IH);

`ifdef CLKDIV_ARBITER_ABORT_EN
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) abort <= 1'b0;
        else         abort <= (state == START || state == RUN) && (abort || !req_i[owner]);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (div_idle_i && |win_gnt) next = (win_len != '0) ? START : DONE;
            START:   if (!div_idle_i) next = RUN;
                     else if (abort) next = DRAIN;
            RUN:     if (ret_edge && (cnt_inc == len || abort)) next = DRAIN;
            DRAIN:   if (div_idle_i) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            len      <= '0;
            cnt      <= '0;
            past_clk <= IH;
            done_o   <= '0;
        end else begin
            state    <= next;
            past_clk <= div_clk_i;
            done_o   <= (state == DONE) ? own_oh : '0;
            if (state == IDLE && next != IDLE) begin
                owner <= win_idx;
                len   <= win_len;
                cnt   <= '0;
                ptr   <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            end else if (state == RUN && ret_edge) begin
                cnt <= cnt_inc;
            end
        end

    // Enable for period k+1 must already be low when the divider samples at edge len.
    assign busy_o       = (state == START) || (state == RUN) || (state == DRAIN) || (state == DONE);
    assign gnt_o        = busy_o ? own_oh : '0;
    assign cnt_o        = cnt;
    assign div_enable_o = (state == START) ? !abort :
                          (state == RUN)   ? (cnt_inc < len) && !abort : 1'b0;

endmodule

// File: tb/tb_clkdiv_arbiter.sv
// tb_clkdiv_arbiter: scoreboard bench with a behavioural DIV=4 divider and randomized bursts.
module tb_clkdiv_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_i;
    logic [7:0] len_i;
    logic [1:0] gnt_o, done_o;
    logic       busy_o, div_en, div_idle;
    logic [3:0] cnt_o;

    logic       dv_run = 1'b0, dv_cont = 1'b0, dv_clk = 1'b1;
    logic [1:0] dv_c = 2'd0;

    typedef struct {
        int owner;
        int cnt;
        int pulses;
        int en;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   vecs = 0, errs = 0, ptr_m = 0;
    int   pulses = 0, en_cyc = 0;
    logic prev_gnt = 1'b0, prev_clk = 1'b1;

    always #5 clk = ~clk;

    clkdiv_arbiter #(.NREQ(2), .LEN_W(4), .IDLE_HIGH(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req_i),
        .len_i        (len_i),
        .gnt_o        (gnt_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .cnt_o        (cnt_o),
        .div_enable_o (div_en),
        .div_idle_i   (div_idle),
        .div_clk_i    (dv_clk)
    );

    // Divider stand-in: DIV=4, idles high, 2 low + 2 high per period, no reset.
    // Enable is sampled at each return edge to decide whether another period follows.
    always @(posedge clk) begin
        if (!dv_run) begin
            if (div_en) begin
                dv_run <= 1'b1;
                dv_c   <= 2'd0;
                dv_clk <= 1'b0;
            end
        end else begin
            dv_c <= dv_c + 2'd1;
            if (dv_c == 2'd1) begin
                dv_clk  <= 1'b1;
                dv_cont <= div_en;
            end
            if (dv_c == 2'd3) begin
                if (dv_cont) dv_clk <= 1'b0;
                else         dv_run <= 1'b0;
            end
        end
    end
    assign div_idle = !dv_run && !div_en;

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each requester in mask is served once, in round-robin order from ptr_m.
    task automatic launch(input logic [1:0] mask, input int l0, input int l1);
        logic [1:0] rem;
        int   w;
        exp_t e;
        len_i = {4'(l1), 4'(l0)};
        rem   = mask;
        while (rem != 2'b00) begin
            w        = rem[ptr_m] ? ptr_m : (ptr_m + 1) % 2;
            e.owner  = w;
            e.cnt    = (w == 0) ? l0 : l1;
            e.pulses = e.cnt;
            e.en     = (e.cnt < 2) ? e.cnt : -1;
            q.push_back(e);
            rem[w] = 1'b0;
            ptr_m  = (w + 1) % 2;
        end
        req_i = mask;
    endtask

    task automatic serve();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            req_i = req_i & ~done_o;
            n++;
        end
        chk("serve_pending", q.size(), 0);
        q.delete();
        @(negedge clk);
        req_i = 2'b00;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt_o != 2'b00 && prev_gnt == 1'b0) begin
                pulses = 0;
                en_cyc = div_en ? 1 : 0;
                if (q.size() == 0) chk("gnt_unexpected", int'(gnt_o), 0);
                else               chk("gnt_owner", int'(gnt_o), 1 << q[0].owner);
            end else begin
                if (div_en) en_cyc++;
                if (dv_clk && !prev_clk) pulses++;
            end
            if (done_o != 2'b00) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", int'(done_o), 0);
                end else begin
                    e_m = q.pop_front();
                    chk("done_owner", int'(done_o), 1 << e_m.owner);
                    chk("cnt", int'(cnt_o), e_m.cnt);
                    chk("pulses", pulses, e_m.pulses);
                    if (e_m.en >= 0) chk("enable_cycles", en_cyc, e_m.en);
                end
            end
        end
        prev_gnt = |gnt_o;
        prev_clk = dv_clk;
    end

    initial begin
        int n;
        rst_n = 1'b0;
        req_i = 2'b00;
        len_i = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_gnt", int'(gnt_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_cnt", int'(cnt_o), 0);
        chk("rst_enable", int'(div_en), 0);
        rst_n = 1'b1;
        @(negedge clk);

        launch(2'b01, 3, 0);  serve();
        launch(2'b11, 2, 2);  serve();
        launch(2'b11, 2, 2);  serve();
        launch(2'b10, 0, 1);  serve();
        launch(2'b01, 0, 0);  serve();

        // Reset in the middle of a burst, request held throughout.
        launch(2'b01, 5, 0);
        n = 0;
        while (!(busy_o && cnt_o == 4'd1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach_cnt1", int'(cnt_o), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_gnt", int'(gnt_o), 0);
        chk("arst_done", int'(done_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_cnt", int'(cnt_o), 0);
        chk("arst_enable", int'(div_en), 0);
        q.delete();
        ptr_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        launch(2'b01, 5, 0);
        n = 0;
        while (!div_idle && n < 200) begin
            chk("no_gnt_while_div_busy", int'(gnt_o), 0);
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("gnt_after_div_idle", int'(gnt_o), 1);
        serve();

        // Owner drops its request after the 2nd return edge.
        launch(2'b01, 8, 0);
`ifdef CLKDIV_ARBITER_ABORT_EN
        q[0].cnt    = 3;
        q[0].pulses = 3;
`endif
        n = 0;
        while (gnt_o == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        while (pulses < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drop_after_2nd_edge", pulses, 2);
        req_i[0] = 1'b0;
        serve();

        for (int i = 0; i < 25; i++) begin
            launch(2'($urandom_range(1, 3)), $urandom_range(0, 15), $urandom_range(0, 15));
            serve();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
